// File: rtl/m_store_align_pkg.sv
// Shared types for the M-stage store path: store opcodes and the entry FSM states.
package m_store_align_pkg;

   typedef enum logic [1:0] {
      ST_NONE = 2'b00,
      ST_SB   = 2'b01,
      ST_SH   = 2'b10,
      ST_SW   = 2'b11
   } st_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } st_state_e;

endpackage

// File: rtl/m_store_lane.sv
// Store lane steering: replicates narrow data across lanes, builds byte enables, flags misalignment.
module m_store_lane
   import m_store_align_pkg::*;
#(
   parameter int DW = 32
) (
   input  st_op_e          op,
   input  logic [1:0]      addr_lo,
   input  logic [DW-1:0]   data,
   output logic [3:0]      be,
   output logic [DW-1:0]   wdata,
   output logic            misaligned
);

   always_comb begin
      be         = 4'b0000;
      wdata      = '0;
      misaligned = 1'b0;
      case (op)
         ST_SB: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{data[7:0]}};
         end
         ST_SH: begin
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{data[15:0]}};
            misaligned = addr_lo[0];
         end
         ST_SW: begin
            be         = 4'b1111;
            wdata      = data;
            misaligned = |addr_lo;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/m_store_align.sv
// M-stage store buffer: one entry, issued to memory with valid/ready; misaligned stores raise AdES instead.
module m_store_align
   import m_store_align_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            out_ready,
   input  logic [1:0]      in_op,
   input  logic [AW-1:0]   in_addr,
   input  logic [DW-1:0]   in_data,
   input  logic [31:0]     in_pc,
   output logic            out_mem_valid,
   input  logic            in_mem_ready,
   output logic [AW-1:0]   out_mem_addr,
   output logic [DW-1:0]   out_mem_wdata,
   output logic [3:0]      out_mem_be,
   output logic [31:0]     out_mem_pc,
   output logic            out_exc_ades,
   output logic [31:0]     out_exc_pc
);

   st_state_e       state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic [31:0]     pc_q, pc_d;
   logic            exc_q, exc_d;
   logic [31:0]     exc_pc_q, exc_pc_d;

   logic [3:0]      lane_be;
   logic [DW-1:0]   lane_wdata;
   logic            lane_mis;
   logic            accept;
   logic            load;
   logic            drain;

   m_store_lane #(.DW(DW)) u_lane (
      .op         (st_op_e'(in_op)),
      .addr_lo    (in_addr[1:0]),
      .data       (in_data),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .misaligned (lane_mis)
   );

   // Valid/ready: a request moves when in_valid & out_ready; the entry retires when
   // out_mem_valid & in_mem_ready. out_ready never looks at in_valid.
   assign out_ready = (state_q == S_IDLE) | in_mem_ready;
   assign accept    = in_valid & out_ready;
   assign load      = accept & (st_op_e'(in_op) != ST_NONE) & ~lane_mis;
   assign drain     = (state_q == S_HOLD) & in_mem_ready;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      pc_d     = pc_q;
      exc_d    = accept & lane_mis;
      exc_pc_d = exc_pc_q;
      if (load) begin
         state_d = S_HOLD;
         addr_d  = {in_addr[AW-1:2], 2'b00};
         wdata_d = lane_wdata;
         be_d    = lane_be;
         pc_d    = in_pc;
      end else if (drain) begin
         state_d = S_IDLE;
      end
      if (accept & lane_mis) begin
         exc_pc_d = in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         pc_q     <= '0;
         exc_q    <= 1'b0;
         exc_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         pc_q     <= pc_d;
         exc_q    <= exc_d;
         exc_pc_q <= exc_pc_d;
      end
   end

   assign out_mem_valid = (state_q == S_HOLD);
   assign out_mem_addr  = addr_q;
   assign out_mem_wdata = wdata_q;
   assign out_mem_be    = be_q;
   assign out_mem_pc    = pc_q;
   assign out_exc_ades  = exc_q;
   assign out_exc_pc    = exc_pc_q;

endmodule

// File: tb/tb_m_store_align.sv
// Bench for m_store_align: directed scenarios then random traffic against an arithmetic store model.
module tb_m_store_align;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          out_ready;
   logic [1:0]    in_op;
   logic [31:0]   in_addr;
   logic [31:0]   in_data;
   logic [31:0]   in_pc;
   logic          out_mem_valid;
   logic          in_mem_ready;
   logic [31:0]   out_mem_addr;
   logic [31:0]   out_mem_wdata;
   logic [3:0]    out_mem_be;
   logic [31:0]   out_mem_pc;
   logic          out_exc_ades;
   logic [31:0]   out_exc_pc;

   int n_checks = 0;
   int n_errors = 0;

   // Model of the single entry and the exception pulse.
   logic          m_hold = 1'b0;
   logic [31:0]   m_addr, m_wdata, m_pc, m_exc_pc;
   logic [3:0]    m_be;
   logic          m_exc = 1'b0;
   logic [67:0]   exp_q[$];

   always #5 clk = ~clk;

   m_store_align dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .out_ready     (out_ready),
      .in_op         (in_op),
      .in_addr       (in_addr),
      .in_data       (in_data),
      .in_pc         (in_pc),
      .out_mem_valid (out_mem_valid),
      .in_mem_ready  (in_mem_ready),
      .out_mem_addr  (out_mem_addr),
      .out_mem_wdata (out_mem_wdata),
      .out_mem_be    (out_mem_be),
      .out_mem_pc    (out_mem_pc),
      .out_exc_ades  (out_exc_ades),
      .out_exc_pc    (out_exc_pc)
   );

   task automatic check_val(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int op_size(input logic [1:0] op);
      case (op)
         2'b01:   return 1;
         2'b10:   return 2;
         2'b11:   return 4;
         default: return 0;
      endcase
   endfunction

   // One clock: apply inputs, check the pre-edge view, advance the model, check post-edge outputs.
   task automatic cyc(input logic rst_n, input logic valid, input logic [1:0] op,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] pc, input logic mem_ready);
      int     sz;
      int     lane;
      logic   acc, mis, ld;
      logic [67:0] w;
      reset        = rst_n;
      in_valid     = valid;
      in_op        = op;
      in_addr      = addr;
      in_data      = data;
      in_pc        = pc;
      in_mem_ready = mem_ready;
      #1;
      if (rst_n) begin
         check_val("out_ready", 68'(out_ready), 68'(!m_hold || mem_ready));
         if (out_mem_valid === 1'b1 && mem_ready) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_write", {out_mem_addr, out_mem_be, out_mem_wdata}, 68'h0);
            end else begin
               w = exp_q.pop_front();
               check_val("write", {out_mem_addr, out_mem_be, out_mem_wdata}, w);
            end
         end
      end
      if (!rst_n) begin
         m_hold = 1'b0; m_addr = 0; m_wdata = 0; m_be = 0; m_pc = 0;
         m_exc = 1'b0; m_exc_pc = 0;
         exp_q.delete();
      end else begin
         sz   = op_size(op);
         acc  = valid && (!m_hold || mem_ready);
         mis  = (sz != 0) && ((addr % sz) != 0);
         ld   = acc && (sz != 0) && !mis;
         lane = int'(addr % 4);
         if (ld) begin
            m_hold = 1'b1;
            m_addr = addr - (addr % 4);
            m_pc   = pc;
            if (sz == 1) begin
               m_be    = 4'(1 << lane);
               m_wdata = (data % 256) * 32'h01010101;
            end else if (sz == 2) begin
               m_be    = 4'(3 << lane);
               m_wdata = (data % 65536) * 32'h00010001;
            end else begin
               m_be    = 4'hf;
               m_wdata = data;
            end
            exp_q.push_back({m_addr, m_be, m_wdata});
         end else if (m_hold && mem_ready) begin
            m_hold = 1'b0;
         end
         m_exc = acc && mis;
         if (m_exc) m_exc_pc = pc;
      end
      @(posedge clk);
      @(negedge clk);
      check_val("mem_valid", 68'(out_mem_valid), 68'(m_hold));
      check_val("exc_ades", 68'(out_exc_ades), 68'(m_exc));
      if (m_hold) begin
         check_val("mem_addr", 68'(out_mem_addr), 68'(m_addr));
         check_val("mem_be", 68'(out_mem_be), 68'(m_be));
         check_val("mem_wdata", 68'(out_mem_wdata), 68'(m_wdata));
         check_val("mem_pc", 68'(out_mem_pc), 68'(m_pc));
      end
      if (m_exc) check_val("exc_pc", 68'(out_exc_pc), 68'(m_exc_pc));
   endtask

   task automatic idle(input logic mem_ready);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, mem_ready);
   endtask

   task automatic check_reset_outputs();
      check_val("rst_mem_valid", 68'(out_mem_valid), 68'h0);
      check_val("rst_mem_addr", 68'(out_mem_addr), 68'h0);
      check_val("rst_mem_wdata", 68'(out_mem_wdata), 68'h0);
      check_val("rst_mem_be", 68'(out_mem_be), 68'h0);
      check_val("rst_mem_pc", 68'(out_mem_pc), 68'h0);
      check_val("rst_exc", 68'(out_exc_ades), 68'h0);
      check_val("rst_exc_pc", 68'(out_exc_pc), 68'h0);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_addr;
      // Reset held with junk on the inputs: reset must win.
      cyc(1'b0, 1'b1, 2'b11, 32'h100, 32'hdeadbeef, 32'h4, 1'b1);
      cyc(1'b0, 1'b1, 2'b11, 32'h100, 32'hdeadbeef, 32'h4, 1'b1);
      check_reset_outputs();

      // SB to the top lane.
      cyc(1'b1, 1'b1, 2'b01, 32'h1003, 32'haabbccdd, 32'h400, 1'b1);
      check_val("t1_addr", 68'(out_mem_addr), 68'h1000);
      check_val("t1_be", 68'(out_mem_be), 68'b1000);
      check_val("t1_wdata", 68'(out_mem_wdata), 68'hdddddddd);
      idle(1'b1);

      // SH aligned, then SH misaligned.
      cyc(1'b1, 1'b1, 2'b10, 32'h2002, 32'h12345678, 32'h404, 1'b1);
      check_val("t2_be", 68'(out_mem_be), 68'b1100);
      check_val("t2_wdata", 68'(out_mem_wdata), 68'h56785678);
      cyc(1'b1, 1'b1, 2'b10, 32'h2001, 32'h12345678, 32'h408, 1'b1);
      check_val("t2_exc_pc", 68'(out_exc_pc), 68'h408);
      idle(1'b1);
      check_val("t2_pulse_end", 68'(out_exc_ades), 68'h0);

      // SW held for three cycles of backpressure, then drained.
      cyc(1'b1, 1'b1, 2'b11, 32'h30, 32'h0badf00d, 32'h40c, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(1'b0);
         check_val("t3_hold_addr", 68'(out_mem_addr), 68'h30);
      end
      idle(1'b1);
      check_val("t3_idle", 68'(out_mem_valid), 68'h0);

      // Streaming SW with memory always ready.
      cyc(1'b1, 1'b1, 2'b11, 32'h40, 32'h11111111, 32'h410, 1'b1);
      cyc(1'b1, 1'b1, 2'b11, 32'h44, 32'h22222222, 32'h414, 1'b1);
      check_val("t4_second", 68'(out_mem_addr), 68'h44);
      cyc(1'b1, 1'b1, 2'b11, 32'h48, 32'h33333333, 32'h418, 1'b1);
      idle(1'b1);

      // Reset while an entry waits on memory: it must never be written.
      cyc(1'b1, 1'b1, 2'b11, 32'h50, 32'h55555555, 32'h41c, 1'b0);
      idle(1'b0);
      cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
      check_reset_outputs();
      idle(1'b1);
      idle(1'b1);

      // Misaligned SW accepted in the drain cycle of a held entry.
      cyc(1'b1, 1'b1, 2'b11, 32'h60, 32'h66666666, 32'h420, 1'b0);
      idle(1'b0);
      cyc(1'b1, 1'b1, 2'b11, 32'h63, 32'h77777777, 32'h424, 1'b1);
      check_val("t6_exc_pc", 68'(out_exc_pc), 68'h424);
      idle(1'b1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         r_op   = 2'($urandom_range(0, 3));
         r_addr = {$urandom_range(0, 255) << 2} | 32'($urandom_range(0, 3));
         cyc(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), r_op, r_addr,
             $urandom, $urandom, ($urandom_range(0, 3) != 0));
      end
      idle(1'b1);
      idle(1'b1);
      check_val("queue_empty", 68'(exp_q.size()), 68'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
